// File: rtl/deconcat_norm.sv
// Splits the {sign, exponent, mantissa} adder word into single-precision fields, normalising one shift per clock.
// Optional round-to-nearest-even stage enabled by defining ROUND_NEAREST_EN.
module deconcat_norm #(
    parameter int EXP_W  = 8,
    parameter int MANT_W = 48,
    parameter int FRAC_W = 23
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    in_valid,
    output logic                    in_ready,
    input  logic [EXP_W+MANT_W:0]   mantise_conc,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic                    sign_o,
    output logic [EXP_W-1:0]        exp_o,
    output logic [FRAC_W-1:0]       frac_o,
    output logic                    busy
);

    localparam logic [EXP_W:0] EXP_MAX = {1'b0, {EXP_W{1'b1}}};
    localparam logic [EXP_W:0] EXP_ONE = {{EXP_W{1'b0}}, 1'b1};
    localparam int OVF_BIT = MANT_W - 1;
    localparam int HID_BIT = MANT_W - 2;
    localparam int FTOP    = MANT_W - 3;

    typedef enum logic [1:0] {IDLE = 2'd0, NORM = 2'd1, ROUND = 2'd2, DONE = 2'd3} state_t;

`ifdef ROUND_NEAREST_EN
    localparam state_t GO_ST = ROUND;
    localparam int GBIT = FTOP - FRAC_W;
`else
    localparam state_t GO_ST = DONE;
`endif

    state_t              state_r, state_s;
    logic                sign_r, sign_s;
    logic [EXP_W:0]      exp_r, exp_s, exp_inc_s;
    logic [MANT_W-1:0]   mant_r, mant_s;
    logic                stay_s;
    logic                load_out_s;
    logic [EXP_W-1:0]    res_exp_s;
    logic [FRAC_W-1:0]   res_frac_s;

    // State register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r <= IDLE;
        end else begin
            state_r <= state_s;
        end
    end

    // Next-state selection
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:    if (in_valid && in_ready) state_s = NORM;  else state_s = IDLE;
            NORM:    if (stay_s)               state_s = NORM;  else state_s = GO_ST;
            ROUND:   state_s = DONE;
            DONE:    if (out_valid && out_ready) state_s = IDLE; else state_s = DONE;
            default: state_s = IDLE;
        endcase
    end

    // Datapath next values: capture in IDLE, one normalisation rule per clock in NORM
    always_comb begin
        sign_s    = sign_r;
        exp_s     = exp_r;
        mant_s    = mant_r;
        stay_s    = 1'b0;
        exp_inc_s = exp_r + EXP_ONE;
        case (state_r)
            IDLE: begin
                if (in_valid && in_ready) begin
                    sign_s = mantise_conc[EXP_W+MANT_W];
                    exp_s  = {1'b0, mantise_conc[EXP_W+MANT_W-1 -: EXP_W]};
                    mant_s = mantise_conc[MANT_W-1:0];
                end else begin
                    sign_s = sign_r;
                end
            end
            NORM: begin
                if (exp_r == EXP_MAX) begin
                    stay_s = 1'b0;
                end else if (mant_r == {MANT_W{1'b0}}) begin
                    exp_s = {(EXP_W+1){1'b0}};
                end else if (mant_r[OVF_BIT]) begin
                    // Re-evaluated next clock, which always moves on since bit OVF_BIT is now clear
                    exp_s  = exp_inc_s;
                    stay_s = 1'b1;
                    if (exp_inc_s == EXP_MAX) mant_s = {MANT_W{1'b0}};
                    else                      mant_s = mant_r >> 1;
                end else if (!mant_r[HID_BIT] && (exp_r != {(EXP_W+1){1'b0}})) begin
                    mant_s = mant_r << 1;
                    exp_s  = exp_r - EXP_ONE;
                    stay_s = 1'b1;
                end else begin
                    stay_s = 1'b0;
                end
            end
            default: stay_s = 1'b0;
        endcase
    end

    // Result fields written to the output registers on entry to DONE
    always_comb begin
        res_exp_s  = exp_s[EXP_W-1:0];
        res_frac_s = mant_s[FTOP -: FRAC_W];
        load_out_s = (state_s == DONE) && (state_r != DONE);
`ifdef ROUND_NEAREST_EN
        if ((state_r == ROUND) && (exp_s != EXP_MAX) && mant_s[GBIT]
            && ((|mant_s[GBIT-1:0]) || mant_s[GBIT+1])) begin
            if (&mant_s[FTOP -: FRAC_W]) begin
                res_frac_s = {FRAC_W{1'b0}};
                res_exp_s  = exp_s[EXP_W-1:0] + {{(EXP_W-1){1'b0}}, 1'b1};
            end else begin
                res_frac_s = mant_s[FTOP -: FRAC_W] + {{(FRAC_W-1){1'b0}}, 1'b1};
            end
        end else begin
            res_frac_s = mant_s[FTOP -: FRAC_W];
        end
`endif
    end

    // Working registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sign_r <= 1'b0;
            exp_r  <= {(EXP_W+1){1'b0}};
            mant_r <= {MANT_W{1'b0}};
        end else begin
            sign_r <= sign_s;
            exp_r  <= exp_s;
            mant_r <= mant_s;
        end
    end

    // Registered handshake and result outputs; results hold until the next load
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            sign_o    <= 1'b0;
            exp_o     <= {EXP_W{1'b0}};
            frac_o    <= {FRAC_W{1'b0}};
        end else begin
            in_ready  <= (state_s == IDLE);
            out_valid <= (state_s == DONE);
            busy      <= (state_s != IDLE);
            if (load_out_s) begin
                sign_o <= sign_s;
                exp_o  <= res_exp_s;
                frac_o <= res_frac_s;
            end else begin
                sign_o <= sign_o;
            end
        end
    end

endmodule

// File: tb/tb_deconcat_norm.sv
// Self-checking bench for deconcat_norm: directed vector table, hold/reset sequences, random words vs. model.
module tb_deconcat_norm;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid = 1'b0;
    logic        in_ready;
    logic [56:0] mantise_conc = 57'd0;
    logic        out_valid;
    logic        out_ready = 1'b1;
    logic        sign_o;
    logic [7:0]  exp_o;
    logic [22:0] frac_o;
    logic        busy;

    int checks = 0;
    int errors = 0;

`ifdef ROUND_NEAREST_EN
    localparam int RND_LAT = 1;
`else
    localparam int RND_LAT = 0;
`endif

    deconcat_norm dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
        .mantise_conc(mantise_conc), .out_valid(out_valid), .out_ready(out_ready),
        .sign_o(sign_o), .exp_o(exp_o), .frac_o(frac_o), .busy(busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [56:0] w;
        logic        s;
        logic [7:0]  e;
        logic [22:0] f;
        int          lat;
    } vec_t;

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
        end
    endtask

    // Reference: normalise by counting leading zeros instead of stepping
    task automatic model(input logic [56:0] w, output logic s, output logic [7:0] e,
                         output logic [22:0] f, output int lat);
        logic [47:0] m;
        int ex, p, sh;
        s = w[56];
        ex = int'(w[55:48]);
        m = w[47:0];
        if (ex == 255) begin
            lat = 1;
        end else if (m == 48'd0) begin
            ex = 0; lat = 1;
        end else if (m[47]) begin
            ex = ex + 1;
            m = (ex == 255) ? 48'd0 : (m >> 1);
            lat = 2;
        end else begin
            p = 0;
            for (int i = 46; i >= 0; i--) if (m[i] && p == 0 && i != 0) p = i;
            sh = 46 - p;
            if (sh > ex) sh = ex;
            ex = ex - sh;
            m = m << sh;
            lat = sh + 1;
        end
        f = m[45:23];
`ifdef ROUND_NEAREST_EN
        if (ex != 255 && m[22] && ((m[21:0] != 22'd0) || m[23])) begin
            if (f == 23'h7FFFFF) begin f = 23'd0; ex = ex + 1; end
            else f = f + 23'd1;
        end
`endif
        e = ex[7:0];
        lat = lat + RND_LAT;
    endtask

    task automatic apply(input logic [56:0] w, input logic es, input logic [7:0] ee,
                         input logic [22:0] ef, input int el, input string nm);
        int n;
        int cyc;
        logic busy_ok;
        n = 0;
        while (!in_ready && n < 200) begin @(posedge clk); #1; n++; end
        chk({nm, "_in_ready"}, in_ready, 1);
        @(negedge clk);
        mantise_conc = w;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        cyc = 0;
        busy_ok = 1'b1;
        while (!out_valid && cyc < 200) begin
            if (!busy) busy_ok = 1'b0;
            @(posedge clk); #1;
            cyc++;
        end
        chk({nm, "_latency"}, cyc, el);
        chk({nm, "_busy"}, busy_ok & busy, 1);
        chk({nm, "_sign"}, sign_o, es);
        chk({nm, "_exp"}, exp_o, ee);
        chk({nm, "_frac"}, frac_o, ef);
        @(posedge clk); #1;
        chk({nm, "_release"}, in_ready, out_ready);
    endtask

    vec_t tbl[10];

    initial begin
        logic        ms;
        logic [7:0]  me;
        logic [22:0] mf;
        int          ml;
        logic [56:0] w;
        logic [47:0] m;

        tbl[0] = '{{1'b0, 8'd127, 48'h4000_0000_0000}, 1'b0, 8'd127, 23'd0,        1};
        tbl[1] = '{{1'b1, 8'd130, 48'h8000_0000_0000}, 1'b1, 8'd131, 23'd0,        2};
        tbl[2] = '{{1'b0, 8'd127, 48'h0000_4000_0000}, 1'b0, 8'd111, 23'd0,        17};
        tbl[3] = '{{1'b0, 8'd3,   48'h0001_0000_0000}, 1'b0, 8'd0,   23'h001000,   4};
        tbl[4] = '{{1'b1, 8'd200, 48'h0},              1'b1, 8'd0,   23'd0,        1};
        tbl[5] = '{{1'b0, 8'd254, 48'h8000_0000_0000}, 1'b0, 8'd255, 23'd0,        2};
        tbl[6] = '{{1'b0, 8'd255, 48'h4000_0080_0000}, 1'b0, 8'd255, 23'd1,        1};
        tbl[7] = '{{1'b0, 8'd200, 48'h0000_0000_0001}, 1'b0, 8'd154, 23'd0,        47};
        tbl[8] = '{{1'b1, 8'd100, 48'h7ABC_DE00_0000}, 1'b1, 8'd100, 23'h7579BC,   1};
        tbl[9] = '{{1'b0, 8'd10,  48'hC000_0000_0000}, 1'b0, 8'd11,  23'h400000,   2};

        // Reset state
        repeat (3) @(posedge clk);
        #1;
        chk("rst_in_ready", in_ready, 1);
        chk("rst_out_valid", out_valid, 0);
        chk("rst_busy", busy, 0);
        chk("rst_fields", {sign_o, exp_o, frac_o}, 0);
        @(negedge clk);
        rst = 1'b0;

        for (int i = 0; i < 10; i++)
            apply(tbl[i].w, tbl[i].s, tbl[i].e, tbl[i].f, tbl[i].lat + RND_LAT, $sformatf("vec%0d", i));

        // Backpressure: outputs held, new input ignored
        out_ready = 1'b0;
        apply(tbl[8].w, tbl[8].s, tbl[8].e, tbl[8].f, tbl[8].lat + RND_LAT, "hold");
        mantise_conc = tbl[0].w;
        in_valid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            @(posedge clk); #1;
            chk("hold_stable", {out_valid, in_ready, sign_o, exp_o, frac_o},
                {1'b1, 1'b0, tbl[8].s, tbl[8].e, tbl[8].f});
        end
        @(negedge clk);
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        chk("hold_release", {in_ready, out_valid}, 2'b10);

        // Asynchronous reset in the middle of a long normalisation
        @(negedge clk);
        mantise_conc = tbl[2].w;
        in_valid = 1'b1;
        @(posedge clk); #1;
        in_valid = 1'b0;
        repeat (5) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        chk("midrst_out_valid", out_valid, 0);
        chk("midrst_in_ready", in_ready, 1);
        chk("midrst_busy", busy, 0);
        @(negedge clk);
        rst = 1'b0;
        apply(tbl[0].w, tbl[0].s, tbl[0].e, tbl[0].f, tbl[0].lat + RND_LAT, "post_rst");

        // Random words against the reference model
        for (int r = 0; r < 150; r++) begin
            m = {$urandom, $urandom} >> $urandom_range(0, 16);
            m = m >> $urandom_range(0, 47);
            if ($urandom_range(0, 15) == 0) m = 48'd0;
            w = {1'(($urandom_range(0, 1))), 8'($urandom_range(0, 255)), m};
            if ($urandom_range(0, 7) == 0) w[55:48] = 8'd255;
            model(w, ms, me, mf, ml);
            apply(w, ms, me, mf, ml, $sformatf("rnd%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
